// File: rtl/vga_pkg.sv
// Shared VGA definitions: RGB333 pixel type, pattern modes, 640x480 timing, colours.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: none; the helper is purely combinational.
package vga_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb333_t;

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    CHECKER  = 2'd1,
    GRADIENT = 2'd2,
    BOUNCE   = 2'd3
  } pattern_mode_e;

  // 640x480@60 timing, identical to the numbers vga_controller uses.
  localparam int VGA_H_SYNC_PULSE  = 96;
  localparam int VGA_H_BACK_PORCH  = 48;
  localparam int VGA_H_DISPLAY     = 640;
  localparam int VGA_H_FRONT_PORCH = 16;
  localparam int VGA_V_SYNC_PULSE  = 2;
  localparam int VGA_V_BACK_PORCH  = 33;
  localparam int VGA_V_DISPLAY     = 480;
  localparam int VGA_V_FRONT_PORCH = 10;

  localparam rgb333_t WHITE = 9'h1FF;
  localparam rgb333_t BLACK = 9'h000;
  localparam rgb333_t RED   = 9'h1C0;
  localparam rgb333_t BLUE  = 9'h007;

  // One frame step of a bouncing coordinate. Returns {new_dir_neg, new_pos}.
  // At either wall the direction flips and the position already moves one
  // step back inside, so the square never sits on a wall for two frames.
  function automatic logic [10:0] bounce_step(input logic [9:0] pos,
                                               input logic       neg,
                                               input logic [9:0] lim);
    if (!neg && pos == lim)      return {1'b1, pos - 10'd1};
    else if (neg && pos == 10'd0) return {1'b0, 10'd1};
    else if (neg)                 return {1'b1, pos - 10'd1};
    else                          return {1'b0, pos + 10'd1};
  endfunction

endpackage

// File: rtl/vga_pattern_gen_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, one-shot rise pulse.
// Latency: 2 sync clks + DEBOUNCE_CYCLES clks from a clean input change to rise_pulse.
// Backpressure: rise_pulse holds until the next clk_en cycle so a gated consumer cannot miss it.
// Ports: clk, rst_n (async active-low), clk_en (consumer enable), btn (raw async), rise_pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic btn,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          db_q;
  logic [CW-1:0] stable_cnt;
  logic          settle;
  logic          rise;

  // The debounced level flips on the DEBOUNCE_CYCLES-th consecutive sample
  // that disagrees with it; any agreeing sample restarts the count.
  assign settle = (sync_q2 != db_q) && (stable_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise   = settle && sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      db_q       <= 1'b0;
      stable_cnt <= '0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      if (sync_q2 == db_q) begin
        stable_cnt <= '0;
      end else if (settle) begin
        db_q       <= sync_q2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
      if (rise)        rise_pulse <= 1'b1;
      else if (clk_en) rise_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern source for vga_controller: recovers x/y from syncs, renders BARS/CHECKER/GRADIENT/BOUNCE.
// Latency: pixel is registered, one clk_en cycle after the h_cnt/v_cnt it was computed from.
// Backpressure: none; free-running on clk_en, button presses queue as a single pending step.
// Ports: clk, rst_n, clk_en (25 MHz enable), h_sync/v_sync (active high), btn_next (raw),
//        pixel (RGB333 to controller sw), mode (current pattern).
// Build option: define PATGEN_BORDER_EN to draw a white 1-pixel frame around the active area.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_BACK_PORCH    = VGA_H_BACK_PORCH,
  parameter int H_DISPLAY_TIME  = VGA_H_DISPLAY,
  parameter int V_BACK_PORCH    = VGA_V_BACK_PORCH,
  parameter int V_DISPLAY_TIME  = VGA_V_DISPLAY,
  parameter int SQ_SIZE         = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       btn_next,
  output logic [8:0] pixel,
  output logic [1:0] mode
);

  localparam logic [9:0] H_ACT_BEG = 10'(H_BACK_PORCH);
  localparam logic [9:0] H_ACT_END = 10'(H_BACK_PORCH + H_DISPLAY_TIME);
  localparam logic [9:0] V_ACT_BEG = 10'(V_BACK_PORCH);
  localparam logic [9:0] V_ACT_END = 10'(V_BACK_PORCH + V_DISPLAY_TIME);
  localparam logic [9:0] BAR_W     = 10'(H_DISPLAY_TIME / 8);  // 80 at 640 wide
  localparam logic [9:0] SQ_X_MAX  = 10'(H_DISPLAY_TIME - SQ_SIZE);
  localparam logic [9:0] SQ_Y_MAX  = 10'(V_DISPLAY_TIME - SQ_SIZE);

  logic          h_sync_q, v_sync_q;
  logic          hfall, vfall;
  logic [9:0]    h_cnt, v_cnt;
  logic [9:0]    x, y;
  logic          active;
  logic [2:0]    bar;
  logic          in_sq;
  logic [9:0]    sq_x, sq_y;
  logic          sq_left, sq_up;
  logic [7:0]    frame_cnt;
  pattern_mode_e mode_q;
  logic          pending;
  logic          btn_pulse;
  rgb333_t       pix_nxt, pix_q;
  logic          unused_frame_bits;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .btn        (btn_next),
    .rise_pulse (btn_pulse)
  );

  assign hfall  = h_sync_q & ~h_sync;
  assign vfall  = v_sync_q & ~v_sync;
  assign active = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
                  (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
  assign x      = h_cnt - H_ACT_BEG;
  assign y      = v_cnt - V_ACT_BEG;
  assign bar    = 3'(x / BAR_W);
  assign in_sq  = (x >= sq_x) && ({1'b0, x} < {1'b0, sq_x} + 11'(SQ_SIZE)) &&
                  (y >= sq_y) && ({1'b0, y} < {1'b0, sq_y} + 11'(SQ_SIZE));

  // Gradient only shows the slow middle bits of the frame counter.
  assign unused_frame_bits = ^{frame_cnt[7:6], frame_cnt[2:0]};

  always_comb begin
    pix_nxt = BLACK;
    if (active) begin
      unique case (mode_q)
        BARS:     pix_nxt = {{3{bar[2]}}, {3{bar[1]}}, {3{bar[0]}}};
        CHECKER:  pix_nxt = (x[5] ^ y[5]) ? WHITE : BLACK;
        GRADIENT: pix_nxt = {x[9:7], y[8:6], frame_cnt[5:3]};
        BOUNCE:   pix_nxt = in_sq ? RED : BLUE;
        default:  pix_nxt = BLACK;
      endcase
`ifdef PATGEN_BORDER_EN
      if (x == 10'd0 || x == 10'(H_DISPLAY_TIME - 1) ||
          y == 10'd0 || y == 10'(V_DISPLAY_TIME - 1))
        pix_nxt = WHITE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sync_q  <= 1'b0;
      v_sync_q  <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      sq_x      <= '0;
      sq_y      <= '0;
      sq_left   <= 1'b0;
      sq_up     <= 1'b0;
      mode_q    <= BARS;
      pending   <= 1'b0;
      pix_q     <= BLACK;
    end else if (clk_en) begin
      h_sync_q <= h_sync;
      v_sync_q <= v_sync;
      pix_q    <= pix_nxt;

      // Counters saturate so a missing sync parks them in blanking.
      if (hfall)               h_cnt <= '0;
      else if (h_cnt != '1)    h_cnt <= h_cnt + 10'd1;
      if (vfall)               v_cnt <= '0;
      else if (hfall && v_cnt != '1) v_cnt <= v_cnt + 10'd1;

      // Everything visible per-frame changes only at vfall, so no frame tears.
      if (vfall) begin
        frame_cnt         <= frame_cnt + 8'd1;
        {sq_left, sq_x}   <= bounce_step(sq_x, sq_left, SQ_X_MAX);
        {sq_up, sq_y}     <= bounce_step(sq_y, sq_up, SQ_Y_MAX);
        if (pending) mode_q <= pattern_mode_e'(mode_q + 2'd1);
      end

      // A press landing on the vfall cycle itself survives to the next frame.
      pending <= btn_pulse | (pending & ~vfall);
    end
  end

  assign pixel = pix_q;
  assign mode  = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized bench for vga_pattern_gen on a shrunken raster, checked against an arithmetic model.
// Latency: expects pixel one clk_en after the counts implied by the driven sync position.
// Backpressure: clk_en is randomly withheld; the model only advances on enabled cycles.
module tb_vga_pattern_gen;

  // Small raster keeps full-sweep checking and 20+ frames of bouncing cheap.
  localparam int HS  = 4;    // h_sync pulse, pixels
  localparam int HBP = 3;
  localparam int HD  = 40;
  localparam int HT  = 50;   // pixels per line
  localparam int VS  = 1;    // v_sync pulse, lines
  localparam int VBP = 2;
  localparam int VD  = 34;
  localparam int VT  = 38;   // lines per frame
  localparam int SQ  = 24;
  localparam int DB  = 4;
  localparam int BUDGET = 90000;

  logic       clk = 1'b0;
  logic       rst_n, clk_en, h_sync, v_sync, btn_next;
  logic [8:0] pixel;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  // stimulus position and reference state
  int hc, vc, n, md, btn_left, phase, cyc;
  bit fresh, pend, prev_vs, vf;
  int ep;

  vga_pattern_gen #(
    .H_BACK_PORCH    (HBP),
    .H_DISPLAY_TIME  (HD),
    .V_BACK_PORCH    (VBP),
    .V_DISPLAY_TIME  (VD),
    .SQ_SIZE         (SQ),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .h_sync   (h_sync),
    .v_sync   (v_sync),
    .btn_next (btn_next),
    .pixel    (pixel),
    .mode     (mode)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (frame %0d line %0d px %0d)", tag, got, exp, n, vc, hc);
    end
  endtask

  // Horizontal count seen by the DUT while position (hc,vc) is on the wire:
  // it restarts one pixel after the h_sync falling edge is sampled.
  function automatic int exp_hcnt(input int h, input int v, input bit fr);
    if (fr && v == 0 && h <= HS) return h;
    return (h > HS) ? h - HS - 1 : h + HT - HS - 1;
  endfunction

  // Vertical count = h_sync falls seen since the last v_sync fall.
  function automatic int exp_vcnt(input int h, input int v, input bit fr);
    if (fr) return v + ((h > HS) ? 1 : 0);
    if (v == VS && h == 0) return VT;
    return (v - VS + VT) % VT + ((h > HS) ? 1 : 0);
  endfunction

  // Triangle wave 0..lim..0 with one step per frame.
  function automatic int tri_pos(input int frames, input int lim);
    int p;
    p = frames % (2 * lim);
    return (p <= lim) ? p : 2 * lim - p;
  endfunction

  function automatic int exp_pix(input int hcnt, input int vcnt, input int frames, input int m);
    int x, y, b, sx, sy;
    if (hcnt < HBP || hcnt >= HBP + HD || vcnt < VBP || vcnt >= VBP + VD) return 0;
    x = hcnt - HBP;
    y = vcnt - VBP;
`ifdef PATGEN_BORDER_EN
    if (x == 0 || x == HD - 1 || y == 0 || y == VD - 1) return 'h1FF;
`endif
    case (m)
      0: begin
        b = x / (HD / 8);
        return ((b & 4) != 0 ? 'h1C0 : 0) | ((b & 2) != 0 ? 'h038 : 0) | ((b & 1) != 0 ? 'h007 : 0);
      end
      1: return (((x / 32) + (y / 32)) % 2 == 1) ? 'h1FF : 'h000;
      2: return (((x / 128) % 8) << 6) | (((y / 64) % 8) << 3) | (((frames % 256) / 8) % 8);
      default: begin
        sx = tri_pos(frames, HD - SQ);
        sy = tri_pos(frames, VD - SQ);
        return (x >= sx && x < sx + SQ && y >= sy && y < sy + SQ) ? 'h1C0 : 'h007;
      end
    endcase
  endfunction

  function automatic bit press_frame(input int ph, input int f);
    if (ph == 1) return (f == 1 || f == 3 || f == 5);
    return (f == 1 || f == 2);
  endfunction

  task automatic step();
    @(negedge clk);
    clk_en   = ($urandom_range(0, 7) != 0);
    btn_next = (btn_left > 0);
    if (btn_left > 0) btn_left--;
    vf = 1'b0;
    if (clk_en) begin
      h_sync  = (hc < HS);
      v_sync  = (vc < VS);
      vf      = prev_vs && !v_sync;
      prev_vs = v_sync;
      ep = exp_pix(exp_hcnt(hc, vc, fresh), exp_vcnt(hc, vc, fresh), n, md);
      if (hc == 5) begin
        if (vc == 10 && press_frame(phase, n)) begin
          btn_left = 10;
          pend     = 1'b1;
        end
        // Second clean press in the same frame must not add a step.
        if (vc == 26 && phase == 1 && n == 3) btn_left = 10;
        // Short glitch, below the debounce threshold.
        if (vc == 20 && $urandom_range(0, 1) == 1) btn_left = $urandom_range(1, DB - 1);
      end
    end
    @(posedge clk);
    #1;
    if (clk_en) begin
      if (vf) begin
        n++;
        fresh = 1'b0;
        if (pend) begin
          md   = (md + 1) % 4;
          pend = 1'b0;
        end
      end
      chk("pixel", pixel, ep);
      chk("mode", mode, md);
      hc++;
      if (hc == HT) begin
        hc = 0;
        vc = (vc + 1) % VT;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_pixel", pixel, 0);
    chk("rst_mode", mode, 0);
    clk_en = 1'b0; h_sync = 1'b0; v_sync = 1'b0; btn_next = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hc = 0; vc = 0; n = 0; md = 0; btn_left = 0;
    fresh = 1'b1; pend = 1'b0; prev_vs = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; clk_en = 1'b0; h_sync = 1'b0; v_sync = 1'b0; btn_next = 1'b0;
    do_reset();

    phase = 1;
    cyc   = 0;
    while (!(n == 22 && vc == 10 && hc == 20) && cyc < BUDGET) begin
      step();
      cyc++;
    end
    if (cyc >= BUDGET) chk("phase1_timeout", cyc, BUDGET - 1);
    chk("mode_before_reset", mode, 3);

    // Mid-line, mid-frame reset while a non-black BOUNCE pixel is showing.
    do_reset();

    phase = 2;
    cyc   = 0;
    while (n < 4 && cyc < BUDGET) begin
      step();
      cyc++;
    end
    if (cyc >= BUDGET) chk("phase2_timeout", cyc, BUDGET - 1);
    chk("mode_end", mode, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
